// File: rtl/simd_rf_pkg.sv
// Shared types and selector helpers for the SIMD register file.
// Selectors are passed zero-extended to 32 bits so one helper serves any IDX_BITS.
package simd_rf_pkg;

  typedef enum logic {IDLE, CLEAR} rfState_e;

  typedef struct packed {
    logic        isScalar;
    logic        inRange;
    logic [31:0] idx;
  } selDec_t;

  function automatic selDec_t decodeSel(input logic [31:0] sel, input int idxBits,
                                        input int vecRegs, input int scRegs);
    selDec_t     d;
    logic [31:0] idxMask;
    idxMask    = (32'd1 << idxBits) - 32'd1;
    d.isScalar = |(sel & (32'd1 << idxBits));
    d.idx      = sel & idxMask;
    d.inRange  = d.isScalar ? (d.idx < $unsigned(scRegs)) : (d.idx < $unsigned(vecRegs));
    return d;
  endfunction

  // Vector registers occupy the low pending bits, scalars follow them.
  function automatic logic [31:0] pendIndex(input selDec_t d, input int vecRegs);
    return d.isScalar ? d.idx + $unsigned(vecRegs) : d.idx;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-writeback scoreboard: one bit per register, set beats clear on the same edge.
module rf_scoreboard
  import simd_rf_pkg::*;
#(
  parameter int VEC_REGS = 4,
  parameter int SC_REGS  = 16,
  parameter int IDX_BITS = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              setEn_i,
  input  logic [IDX_BITS:0] setSel_i,
  input  logic              wrCommit_i,
  input  logic [IDX_BITS:0] wrSel_i,
  input  logic              clrAll_i,
  input  logic [IDX_BITS:0] rSel1_i,
  input  logic [IDX_BITS:0] rSel2_i,
  output logic              pend1_o,
  output logic              pend2_o
);

  localparam int NP = VEC_REGS + SC_REGS;

  logic [NP-1:0] pend_q, pend_d;
  selDec_t       setDec, wrDec, rd1Dec, rd2Dec;
  logic [31:0]   setIdx, wrIdx, rd1Idx, rd2Idx;

  assign setDec = decodeSel(32'(setSel_i), IDX_BITS, VEC_REGS, SC_REGS);
  assign wrDec  = decodeSel(32'(wrSel_i), IDX_BITS, VEC_REGS, SC_REGS);
  assign rd1Dec = decodeSel(32'(rSel1_i), IDX_BITS, VEC_REGS, SC_REGS);
  assign rd2Dec = decodeSel(32'(rSel2_i), IDX_BITS, VEC_REGS, SC_REGS);
  assign setIdx = pendIndex(setDec, VEC_REGS);
  assign wrIdx  = pendIndex(wrDec, VEC_REGS);
  assign rd1Idx = pendIndex(rd1Dec, VEC_REGS);
  assign rd2Idx = pendIndex(rd2Dec, VEC_REGS);

  always_comb begin
    pend_d = pend_q;
    for (int b = 0; b < NP; b++) begin
      if (wrCommit_i && wrDec.inRange && (b == wrIdx)) pend_d[b] = 1'b0;
      if (setEn_i && setDec.inRange && (b == setIdx)) pend_d[b] = 1'b1;
    end
    if (clrAll_i) pend_d = '0;
  end

  // Out-of-range selectors can alias a real bit index, so inRange gates the lookup.
  always_comb begin
    pend1_o = 1'b0;
    pend2_o = 1'b0;
    for (int b = 0; b < NP; b++) begin
      if (b == rd1Idx) pend1_o = pend_q[b] & rd1Dec.inRange;
      if (b == rd2Idx) pend2_o = pend_q[b] & rd2Dec.inRange;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) pend_q <= '0;
    else          pend_q <= pend_d;
  end

endmodule

// File: rtl/simd_regfile_sb.sv
// Unified scalar/vector register file with lane masking, write bypass,
// pending-write stall and a sequential bulk-clear engine.
module simd_regfile_sb
  import simd_rf_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int VEC_LANES = 4,
  parameter int VEC_REGS  = 4,
  parameter int SC_REGS   = 16,
  parameter int IDX_BITS  = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                wrEn,
  input  logic [IDX_BITS:0]                   wrSel,
  input  logic [VEC_LANES-1:0]                wrLaneMask,
  input  logic [VEC_LANES-1:0][REG_WIDTH-1:0] wrData,
  input  logic                                rdEn1,
  input  logic                                rdEn2,
  input  logic [IDX_BITS:0]                   rSel1,
  input  logic [IDX_BITS:0]                   rSel2,
  output logic [VEC_LANES-1:0][REG_WIDTH-1:0] operand1,
  output logic [VEC_LANES-1:0][REG_WIDTH-1:0] operand2,
  input  logic                                pendSet,
  input  logic [IDX_BITS:0]                   pendSel,
  input  logic                                clrReq,
  output logic                                busy,
  output logic                                stall
);

  localparam int MAX_REGS = (VEC_REGS > SC_REGS) ? VEC_REGS : SC_REGS;
  localparam int CNT_W    = (MAX_REGS > 1) ? $clog2(MAX_REGS) : 1;

  typedef logic [VEC_LANES-1:0][REG_WIDTH-1:0] laneVec_t;

  laneVec_t             vreg_q [VEC_REGS];
  laneVec_t             vreg_d [VEC_REGS];
  logic [REG_WIDTH-1:0] sreg_q [SC_REGS];
  logic [REG_WIDTH-1:0] sreg_d [SC_REGS];
  rfState_e             state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [31:0]          cntExt;
  selDec_t              wrDec;
  logic                 idle, writeOk, hit1, hit2, pend1, pend2;

  assign cntExt  = 32'(cnt_q);
  assign idle    = (state_q == IDLE);
  assign busy    = (state_q == CLEAR);
  assign wrDec   = decodeSel(32'(wrSel), IDX_BITS, VEC_REGS, SC_REGS);
  assign writeOk = wrEn && idle && wrDec.inRange;
  assign hit1    = writeOk && (rSel1 == wrSel);
  assign hit2    = writeOk && (rSel2 == wrSel);

  // Stored value of the selected register, overlaid with the in-flight write.
  function automatic laneVec_t readPort(input logic [IDX_BITS:0] sel, input logic hit);
    selDec_t  d;
    laneVec_t v;
    d = decodeSel(32'(sel), IDX_BITS, VEC_REGS, SC_REGS);
    v = '0;
    if (d.isScalar) begin
      for (int i = 0; i < SC_REGS; i++)
        if (i == d.idx) v = {VEC_LANES{sreg_q[i]}};
    end else begin
      for (int i = 0; i < VEC_REGS; i++)
        if (i == d.idx) v = vreg_q[i];
    end
    if (hit) begin
      if (wrDec.isScalar) begin
        v = {VEC_LANES{wrData[0]}};
      end else begin
        for (int l = 0; l < VEC_LANES; l++)
          if (wrLaneMask[l]) v[l] = wrData[l];
      end
    end
    return v;
  endfunction

  always_comb begin
    operand1 = readPort(rSel1, hit1);
    operand2 = readPort(rSel2, hit2);
  end

  always_comb begin
    vreg_d  = vreg_q;
    sreg_d  = sreg_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (writeOk) begin
          if (wrDec.isScalar) begin
            for (int i = 0; i < SC_REGS; i++)
              if (i == wrDec.idx) sreg_d[i] = wrData[0];
          end else begin
            for (int i = 0; i < VEC_REGS; i++)
              if (i == wrDec.idx)
                for (int l = 0; l < VEC_LANES; l++)
                  if (wrLaneMask[l]) vreg_d[i][l] = wrData[l];
          end
        end
        if (clrReq) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        for (int i = 0; i < VEC_REGS; i++)
          if (i == cntExt) vreg_d[i] = '0;
        for (int i = 0; i < SC_REGS; i++)
          if (i == cntExt) sreg_d[i] = '0;
        // Exit is decided before incrementing, so the counter never wraps.
        if (cntExt == MAX_REGS - 1) state_d = IDLE;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < VEC_REGS; i++) vreg_q[i] <= '0;
      for (int i = 0; i < SC_REGS; i++)  sreg_q[i] <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      vreg_q  <= vreg_d;
      sreg_q  <= sreg_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  rf_scoreboard #(
    .VEC_REGS (VEC_REGS),
    .SC_REGS  (SC_REGS),
    .IDX_BITS (IDX_BITS)
  ) u_scoreboard (
    .clk_i      (clk),
    .reset_i    (reset),
    .setEn_i    (pendSet && idle),
    .setSel_i   (pendSel),
    .wrCommit_i (writeOk),
    .wrSel_i    (wrSel),
    .clrAll_i   (clrReq && idle),
    .rSel1_i    (rSel1),
    .rSel2_i    (rSel2),
    .pend1_o    (pend1),
    .pend2_o    (pend2)
  );

  assign stall = busy || (rdEn1 && pend1 && !hit1) || (rdEn2 && pend2 && !hit2);

endmodule

// File: tb/tb_simd_regfile_sb.sv
// Scoreboard-driven bench for simd_regfile_sb: expected values are queued when
// stimulus is driven and compared at the following falling edge.
module tb_simd_regfile_sb;

  logic             clk;
  logic             reset;
  logic             wrEn;
  logic [4:0]       wrSel;
  logic [3:0]       wrLaneMask;
  logic [3:0][31:0] wrData;
  logic             rdEn1, rdEn2;
  logic [4:0]       rSel1, rSel2;
  logic [3:0][31:0] operand1, operand2;
  logic             pendSet;
  logic [4:0]       pendSel;
  logic             clrReq;
  logic             busy, stall;

  typedef struct {
    string        tag;
    int           kind;
    logic [127:0] val;
  } expect_t;

  expect_t expQ[$];
  int      compareCount = 0;
  int      failCount    = 0;

  simd_regfile_sb dut (
    .clk        (clk),
    .reset      (reset),
    .wrEn       (wrEn),
    .wrSel      (wrSel),
    .wrLaneMask (wrLaneMask),
    .wrData     (wrData),
    .rdEn1      (rdEn1),
    .rdEn2      (rdEn2),
    .rSel1      (rSel1),
    .rSel2      (rSel2),
    .operand1   (operand1),
    .operand2   (operand2),
    .pendSet    (pendSet),
    .pendSel    (pendSel),
    .clrReq     (clrReq),
    .busy       (busy),
    .stall      (stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 operand1, 1 operand2, 2 stall, 3 busy
  task automatic pushExpect(input string tag, input int kind, input logic [127:0] val);
    expect_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    expQ.push_back(e);
  endtask

  task automatic sample();
    expect_t      e;
    logic [127:0] obs;
    @(negedge clk);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      case (e.kind)
        0:       obs = operand1;
        1:       obs = operand2;
        2:       obs = {127'd0, stall};
        default: obs = {127'd0, busy};
      endcase
      checkOutput(e.tag, obs, e.val);
    end
  endtask

  function automatic logic [127:0] bcast(input logic [31:0] v);
    return {4{v}};
  endfunction

  task automatic applyStimulus(input logic we, input logic [4:0] sel, input logic [3:0] mask,
                               input logic [127:0] data);
    wrEn       = we;
    wrSel      = sel;
    wrLaneMask = mask;
    wrData     = data;
  endtask

  task automatic setRead(input logic e1, input logic [4:0] s1, input logic e2, input logic [4:0] s2);
    rdEn1 = e1;
    rSel1 = s1;
    rdEn2 = e2;
    rSel2 = s2;
  endtask

  task automatic writeReg(input logic [4:0] sel, input logic [3:0] mask, input logic [127:0] data);
    applyStimulus(1'b1, sel, mask, data);
    tick();
    applyStimulus(1'b0, 5'd0, 4'd0, '0);
  endtask

  task automatic markPending(input logic [4:0] sel);
    pendSet = 1'b1;
    pendSel = sel;
    tick();
    pendSet = 1'b0;
  endtask

  function automatic logic [31:0] sclPre(input int k);
    return (k == 9) ? 32'h999 : 32'h100 + 32'(k);
  endfunction

  initial begin
    logic [3:0][31:0] d;

    reset = 1'b0;
    applyStimulus(1'b0, 5'd0, 4'd0, '0);
    setRead(1'b0, 5'd0, 1'b0, 5'd0);
    pendSet = 1'b0;
    pendSel = 5'd0;
    clrReq  = 1'b0;
    tick();
    reset = 1'b1;

    $display("[TB] reset state");
    setRead(1'b1, 5'b0_0010, 1'b1, 5'b1_0111);
    pushExpect("rst_op1", 0, '0);
    pushExpect("rst_op2", 1, '0);
    pushExpect("rst_busy", 3, 128'd0);
    pushExpect("rst_stall", 2, 128'd0);
    sample();
    setRead(1'b0, 5'd0, 1'b0, 5'd0);

    $display("[TB] masked vector write and bypass");
    writeReg(5'b0_0010, 4'b1111, {32'd4, 32'd3, 32'd2, 32'd1});
    applyStimulus(1'b1, 5'b0_0010, 4'b0101, {32'hA, 32'hB, 32'hC, 32'hD});
    setRead(1'b0, 5'b0_0010, 1'b0, 5'b0_0011);
    pushExpect("vec_bypass", 0, {32'd4, 32'hB, 32'd2, 32'hD});
    pushExpect("vec_other", 1, '0);
    sample();
    tick();
    applyStimulus(1'b0, 5'd0, 4'd0, '0);
    pushExpect("vec_stored", 0, {32'd4, 32'hB, 32'd2, 32'hD});
    sample();

    $display("[TB] scalar broadcast");
    writeReg(5'b1_0111, 4'b0000, {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'hDEAD_BEEF});
    setRead(1'b0, 5'b1_0111, 1'b0, 5'b0_0100);
    pushExpect("scl_bcast", 0, bcast(32'hDEAD_BEEF));
    pushExpect("vec_oob_read", 1, '0);
    sample();

    $display("[TB] scoreboard");
    markPending(5'b1_0011);
    setRead(1'b1, 5'b1_0011, 1'b0, 5'd0);
    pushExpect("pend_stall", 2, 128'd1);
    sample();
    setRead(1'b0, 5'b1_0011, 1'b0, 5'd0);
    pushExpect("pend_rden_off", 2, 128'd0);
    sample();
    setRead(1'b1, 5'b1_0011, 1'b0, 5'd0);
    applyStimulus(1'b1, 5'b1_0011, 4'd0, {96'd0, 32'h55});
    pushExpect("pend_bypass_stall", 2, 128'd0);
    pushExpect("pend_bypass_op", 0, bcast(32'h55));
    sample();
    tick();
    applyStimulus(1'b0, 5'd0, 4'd0, '0);
    pushExpect("pend_cleared", 2, 128'd0);
    sample();
    pendSet = 1'b1;
    pendSel = 5'b1_0011;
    applyStimulus(1'b1, 5'b1_0011, 4'd0, {96'd0, 32'h66});
    tick();
    pendSet = 1'b0;
    applyStimulus(1'b0, 5'd0, 4'd0, '0);
    pushExpect("set_wins_stall", 2, 128'd1);
    pushExpect("set_wins_data", 0, bcast(32'h66));
    sample();
    setRead(1'b0, 5'd0, 1'b1, 5'b1_0011);
    pushExpect("pend_port2", 2, 128'd1);
    sample();
    writeReg(5'b1_0011, 4'd0, {96'd0, 32'h77});
    pushExpect("pend_port2_clr", 2, 128'd0);
    sample();
    setRead(1'b0, 5'd0, 1'b0, 5'd0);

    $display("[TB] bulk clear");
    for (int v = 0; v < 4; v++) begin
      for (int l = 0; l < 4; l++) d[l] = 32'h1000 * 32'(v + 1) + 32'(l);
      writeReg({1'b0, 4'(v)}, 4'b1111, d);
    end
    for (int s = 0; s < 16; s++) writeReg({1'b1, 4'(s)}, 4'd0, {96'd0, 32'h100 + 32'(s)});
    setRead(1'b0, 5'b0_0011, 1'b0, 5'b1_1111);
    pushExpect("preload_v3", 0, {32'h4003, 32'h4002, 32'h4001, 32'h4000});
    pushExpect("preload_s15", 1, bcast(32'h10F));
    sample();
    markPending(5'b0_0001);
    markPending(5'b1_0101);
    setRead(1'b1, 5'b0_0001, 1'b1, 5'b1_0101);
    pushExpect("pend_before_clr", 2, 128'd1);
    sample();
    setRead(1'b0, 5'd0, 1'b0, 5'd0);

    clrReq = 1'b1;
    applyStimulus(1'b1, 5'b1_1001, 4'd0, {96'd0, 32'h999});
    tick();
    clrReq = 1'b0;
    applyStimulus(1'b1, 5'b1_1111, 4'b1111, {4{32'hFFFF}});
    pendSet = 1'b1;
    pendSel = 5'b1_0010;
    for (int k = 0; k < 16; k++) begin
      setRead(1'b0, {1'b1, 4'(k)}, 1'b0, (k == 0) ? 5'b0_0000 : {1'b1, 4'(k - 1)});
      pushExpect($sformatf("clr_busy_%0d", k), 3, 128'd1);
      pushExpect($sformatf("clr_stall_%0d", k), 2, 128'd1);
      pushExpect($sformatf("clr_keep_%0d", k), 0, bcast(sclPre(k)));
      pushExpect($sformatf("clr_done_%0d", k), 1,
                 (k == 0) ? {32'h1003, 32'h1002, 32'h1001, 32'h1000} : 128'd0);
      sample();
      tick();
    end
    applyStimulus(1'b0, 5'd0, 4'd0, '0);
    pendSet = 1'b0;
    setRead(1'b1, 5'b0_0001, 1'b1, 5'b1_0101);
    pushExpect("clr_exit_busy", 3, 128'd0);
    pushExpect("clr_pend_gone", 2, 128'd0);
    sample();
    setRead(1'b1, 5'b1_0010, 1'b0, 5'd0);
    pushExpect("clr_pendset_ignored", 2, 128'd0);
    sample();
    for (int r = 0; r < 20; r++) begin
      setRead(1'b0, (r < 4) ? {1'b0, 4'(r)} : {1'b1, 4'(r - 4)}, 1'b0, 5'd0);
      pushExpect($sformatf("clr_zero_%0d", r), 0, '0);
      sample();
      tick();
    end

    $display("[TB] reset during clear");
    writeReg(5'b1_1100, 4'd0, {96'd0, 32'h1212});
    writeReg(5'b0_0011, 4'b1111, {4{32'hAAAA}});
    clrReq = 1'b1;
    tick();
    clrReq = 1'b0;
    repeat (4) tick();
    setRead(1'b0, 5'b1_1100, 1'b0, 5'b0_0011);
    reset = 1'b0;
    pushExpect("midclr_busy", 3, 128'd1);
    pushExpect("midclr_s12", 0, bcast(32'h1212));
    pushExpect("midclr_v3", 1, '0);
    sample();
    tick();
    reset = 1'b1;
    pushExpect("postrst_busy", 3, 128'd0);
    pushExpect("postrst_stall", 2, 128'd0);
    pushExpect("postrst_s12", 0, '0);
    sample();
    writeReg(5'b1_1100, 4'd0, {96'd0, 32'h3});
    pushExpect("postrst_write", 0, bcast(32'h3));
    sample();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
